ifid_queue: RTL and testbench

//  Parametrised IF/ID decoupling queue. Successor to the single-entry IF/ID pipeline register.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/ifid_queue.sv | 109 ++++++++++
 tb/tb_ifid_queue.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: the IF/ID entry layout and the canonical NOP encoding.
// The decode stage and later stage registers also use these types.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
    } ifid_entry_t;

endpackage

// File: rtl/ifid_queue.sv
// IF/ID decoupling queue: a DEPTH-entry circular buffer of {Instr, PC, PC+4} between fetch and
// decode, letting fetch run ahead while decode stalls. Ready_F is meant to drive PC_En.
// Optional feature: define IFID_QUEUE_BYPASS_EN to let a push into an empty queue reach the
// decode outputs in the same cycle; without it, a push becomes visible one cycle later.
// The module XLEN must match riscv_pkg::XLEN, since storage uses the shared ifid_entry_t.
module ifid_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Valid_F,
    input  logic [XLEN-1:0]            Instr_F,
    input  logic [XLEN-1:0]            PC_F,
    input  logic [XLEN-1:0]            PC_Plus_4_F,
    output logic                       Ready_F,
    input  logic                       Stall_D,
    input  logic                       Flush_D,
    output logic                       Valid_D,
    output logic [XLEN-1:0]            Instr_D,
    output logic [XLEN-1:0]            PC_D,
    output logic [XLEN-1:0]            PC_Plus_4_D,
    output logic [$clog2(DEPTH+1)-1:0] Count
);
    import riscv_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    ifid_entry_t   mem [DEPTH];

    ifid_entry_t   entry_in;
    ifid_entry_t   head;
    logic          full;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          q_pop;

    // Handshake decode. Ready_F depends only on occupancy, never on Stall_D.
    always_comb begin
        entry_in = '{instr: Instr_F, pc: PC_F, pc_plus_4: PC_Plus_4_F};
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
`ifdef IFID_QUEUE_BYPASS_EN
        bypass   = empty & Valid_F & ~Flush_D;
`else
        bypass   = 1'b0;
`endif
        push     = Valid_F & ~full;
        pop      = (~empty | bypass) & ~Stall_D;
        // A bypassed entry consumed this cycle is never stored; a stalled one is.
        wr_en    = push & ~(bypass & ~Stall_D);
        q_pop    = pop & ~bypass;
    end

    // Decode-side view: head entry (or bypassed fetch entry), masked to NOP/0 when empty.
    always_comb begin
        head        = bypass ? entry_in : mem[rd_ptr];
        Ready_F     = ~full;
        Valid_D     = ~empty | bypass;
        Count       = count_q;
        Instr_D     = NOP_INSTR;
        PC_D        = '0;
        PC_Plus_4_D = '0;
        if (Valid_D) begin
            Instr_D     = head.instr;
            PC_D        = head.pc;
            PC_Plus_4_D = head.pc_plus_4;
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats push and pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (Flush_D) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({wr_en, q_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are not reset, the pointers define what is live.
    always_ff @(posedge CLK) begin
        if (!RST && !Flush_D && wr_en) begin
            mem[wr_ptr] <= entry_in;
        end
    end

endmodule

// File: tb/tb_ifid_queue.sv
// Bench for ifid_queue: a queue-based reference model checked every cycle, plus directed
// literal expectations. Honors IFID_QUEUE_BYPASS_EN the same way as the design.
module tb_ifid_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            Valid_F = 1'b0;
    logic [XLEN-1:0] Instr_F = '0;
    logic [XLEN-1:0] PC_F = '0;
    logic [XLEN-1:0] PC_Plus_4_F = '0;
    logic            Stall_D = 1'b0;
    logic            Flush_D = 1'b0;
    logic            Ready_F;
    logic            Valid_D;
    logic [XLEN-1:0] Instr_D;
    logic [XLEN-1:0] PC_D;
    logic [XLEN-1:0] PC_Plus_4_D;
    logic [CW-1:0]   Count;

    ifid_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Valid_F     (Valid_F),
        .Instr_F     (Instr_F),
        .PC_F        (PC_F),
        .PC_Plus_4_F (PC_Plus_4_F),
        .Ready_F     (Ready_F),
        .Stall_D     (Stall_D),
        .Flush_D     (Flush_D),
        .Valid_D     (Valid_D),
        .Instr_D     (Instr_D),
        .PC_D        (PC_D),
        .PC_Plus_4_D (PC_Plus_4_D),
        .Count       (Count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    ent_t mq[$];
    bit   model_on = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h0000_0093 ^ (pc << 7);
    endfunction

    function automatic ent_t f_ent();
        ent_t e;
        e.instr = Instr_F;
        e.pc    = PC_F;
        e.pc4   = PC_Plus_4_F;
        return e;
    endfunction

    function automatic bit m_bypass();
`ifdef IFID_QUEUE_BYPASS_EN
        return (mq.size() == 0) && Valid_F && !Flush_D;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_valid();
        return (mq.size() != 0) || m_bypass();
    endfunction

    function automatic ent_t m_head();
        ent_t e;
        e.instr = 32'h00000013;
        e.pc    = '0;
        e.pc4   = '0;
        if (m_bypass()) e = f_ent();
        else if (mq.size() != 0) e = mq[0];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: FIFO of entries, advanced with the inputs seen at each rising edge.
    always @(posedge CLK) begin
        if (RST) begin
            mq.delete();
            model_on <= 1'b1;
        end else if (Flush_D) begin
            mq.delete();
        end else if (m_bypass()) begin
            if (Stall_D) mq.push_back(f_ent());
        end else begin
            if (Valid_F && (mq.size() < DEPTH)) begin
                if ((mq.size() != 0) && !Stall_D) void'(mq.pop_front());
                mq.push_back(f_ent());
            end else if ((mq.size() != 0) && !Stall_D) begin
                void'(mq.pop_front());
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        if (model_on) begin
            check("model_ready", 32'(Ready_F), 32'(mq.size() < DEPTH));
            check("model_valid", 32'(Valid_D), 32'(m_valid()));
            check("model_count", 32'(Count), 32'(mq.size()));
            check("model_instr", Instr_D, m_head().instr);
            check("model_pc", PC_D, m_head().pc);
            check("model_pc4", PC_Plus_4_D, m_head().pc4);
        end
    end

    task automatic cyc(input bit rst, input bit v, input logic [31:0] pc, input bit stall,
                       input bit flush);
        @(posedge CLK);
        #1;
        RST         = rst;
        Valid_F     = v;
        PC_F        = pc;
        Instr_F     = instr_of(pc);
        PC_Plus_4_F = pc + 32'd4;
        Stall_D     = stall;
        Flush_D     = flush;
        @(negedge CLK);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        idle();
        check("rst_valid", 32'(Valid_D), 32'd0);
        check("rst_instr", Instr_D, 32'h00000013);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_ready", 32'(Ready_F), 32'd1);
        check("rst_pc", PC_D, 32'd0);

        // Streaming with decode always consuming
        cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
`ifdef IFID_QUEUE_BYPASS_EN
        check("str0_valid", 32'(Valid_D), 32'd1);
        check("str0_pc", PC_D, 32'h0);
`else
        check("str0_valid", 32'(Valid_D), 32'd0);
`endif
        check("str0_count", 32'(Count), 32'd0);
        cyc(1'b0, 1'b1, 32'h4, 1'b0, 1'b0);
`ifdef IFID_QUEUE_BYPASS_EN
        check("str1_pc", PC_D, 32'h4);
        check("str1_count", 32'(Count), 32'd0);
`else
        check("str1_pc", PC_D, 32'h0);
        check("str1_count", 32'(Count), 32'd1);
`endif
        cyc(1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
`ifdef IFID_QUEUE_BYPASS_EN
        check("str2_pc", PC_D, 32'h8);
`else
        check("str2_pc", PC_D, 32'h4);
`endif
        idle();
`ifndef IFID_QUEUE_BYPASS_EN
        check("str3_pc", PC_D, 32'h8);
        check("str3_instr", Instr_D, instr_of(32'h8));
`endif
        idle();
        check("str_end_valid", 32'(Valid_D), 32'd0);

        // Fill while stalled; fifth push held until space frees
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 32'(4 * k), 1'b1, 1'b0);
            check("fill_count", 32'(Count), 32'(k));
            check("fill_ready", 32'(Ready_F), 32'(k < 4));
        end
        cyc(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        check("rel0_count", 32'(Count), 32'd4);
        check("rel0_ready", 32'(Ready_F), 32'd0);
        check("rel0_pc", PC_D, 32'h0);
        cyc(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        check("rel1_count", 32'(Count), 32'd3);
        check("rel1_ready", 32'(Ready_F), 32'd1);
        check("rel1_pc", PC_D, 32'h4);
        idle();
        check("rel2_count", 32'(Count), 32'd3);
        check("rel2_pc", PC_D, 32'h8);
        idle();
        check("rel3_pc", PC_D, 32'hC);
        idle();
        check("rel4_pc", PC_D, 32'h10);
        check("rel4_pc4", PC_Plus_4_D, 32'h14);
        check("rel4_count", 32'(Count), 32'd1);
        idle();
        check("rel5_valid", 32'(Valid_D), 32'd0);

        // Pointer wrap at constant occupancy of 2
        cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h104, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 32'(32'h108 + 4 * i), 1'b0, 1'b0);
            check("wrap_count", 32'(Count), 32'd2);
            check("wrap_pc", PC_D, 32'(32'h100 + 4 * i));
        end
        idle();
        idle();
        idle();
        check("wrap_end_count", 32'(Count), 32'd0);

        // Flush with a simultaneous push
        cyc(1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h204, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h208, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h20C, 1'b1, 1'b1);
        check("fl_pre_count", 32'(Count), 32'd3);
        idle();
        check("fl_count", 32'(Count), 32'd0);
        check("fl_valid", 32'(Valid_D), 32'd0);
        check("fl_instr", Instr_D, 32'h00000013);
        check("fl_pc4", PC_Plus_4_D, 32'd0);
        cyc(1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
        idle();
        check("fl_post_count", 32'(Count), 32'd1);
        check("fl_post_pc", PC_D, 32'h300);
        idle();
        check("fl_post_empty", 32'(Count), 32'd0);

        // Reset mid-operation
        cyc(1'b0, 1'b1, 32'h400, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h404, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 32'h408, 1'b1, 1'b0);
        check("mrst_pre_count", 32'(Count), 32'd2);
        idle();
        check("mrst_count", 32'(Count), 32'd0);
        check("mrst_valid", 32'(Valid_D), 32'd0);

        // Push into empty queue with decode consuming
        cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
`ifdef IFID_QUEUE_BYPASS_EN
        check("byp0_valid", 32'(Valid_D), 32'd1);
        check("byp0_pc", PC_D, 32'h40);
`else
        check("byp0_valid", 32'(Valid_D), 32'd0);
`endif
        check("byp0_count", 32'(Count), 32'd0);
        idle();
`ifdef IFID_QUEUE_BYPASS_EN
        check("byp1_valid", 32'(Valid_D), 32'd0);
        check("byp1_count", 32'(Count), 32'd0);
`else
        check("byp1_valid", 32'(Valid_D), 32'd1);
        check("byp1_pc", PC_D, 32'h40);
        check("byp1_count", 32'(Count), 32'd1);
`endif
        idle();
        check("byp2_count", 32'(Count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
